// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator (optional FrameCnt via VGA_FRAME_COUNTER_EN)
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PixEn,
    output logic [11:0] Hpos,
    output logic [11:0] Vpos,
    output logic        Hsync,
    output logic        Vsync,
    output logic        Visible,
    output logic        LineStart,
    output logic        FrameStart
`ifdef VGA_FRAME_COUNTER_EN
    ,
    output logic [15:0] FrameCnt
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // All window bounds as 12-bit constants so every compare is width-matched
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
    localparam logic [11:0] HS_FIRST = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_LAST  = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_LAST  = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic        h_last;
    logic        v_last;
    logic [11:0] h_next;
    logic [11:0] v_next;
    logic        hs_next;
    logic        vs_next;
    logic        vis_next;

    // Next-coordinate and decode logic; flags are decoded from the next
    // coordinates so they register in the same edge as Hpos/Vpos.
    always_comb begin
        h_last   = 1'b0;
        v_last   = 1'b0;
        h_next   = Hpos;
        v_next   = Vpos;
        hs_next  = SYNC_OFF;
        vs_next  = SYNC_OFF;
        vis_next = 1'b0;

        h_last = (Hpos == H_LAST);
        v_last = (Vpos == V_LAST);

        if (h_last) begin
            h_next = 12'd0;
            v_next = v_last ? 12'd0 : (Vpos + 12'd1);
        end else begin
            h_next = Hpos + 12'd1;
        end

        // Vpos only moves at the line wrap, so Vsync is line-aligned for free
        hs_next  = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ON : SYNC_OFF;
        vs_next  = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ON : SYNC_OFF;
        vis_next = (h_next < H_VIS) && (v_next < V_VIS);
    end

    // Coordinate and flag registers; everything holds while PixEn is low
    // except the start pulses, which drop to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hpos       <= 12'd0;
            Vpos       <= 12'd0;
            Hsync      <= SYNC_OFF;
            Vsync      <= SYNC_OFF;
            Visible    <= 1'b1;
            LineStart  <= 1'b0;
            FrameStart <= 1'b0;
        end else if (PixEn) begin
            Hpos       <= h_next;
            Vpos       <= v_next;
            Hsync      <= hs_next;
            Vsync      <= vs_next;
            Visible    <= vis_next;
            LineStart  <= h_last;
            FrameStart <= h_last && v_last;
        end else begin
            LineStart  <= 1'b0;
            FrameStart <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // Frame counter steps in the edge that raises FrameStart, wrapping at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FrameCnt <= 16'd0;
        end else if (PixEn && h_last && v_last) begin
            FrameCnt <= FrameCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic pix_en;

    logic [11:0] hpos_d, vpos_d;
    logic        hsync_d, vsync_d, visible_d, ls_d, fs_d;
    logic [11:0] hpos_s, vpos_s;
    logic        hsync_s, vsync_s, visible_s, ls_s, fs_s;
`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] fcnt_d, fcnt_s;
`endif

    int compared;
    int mismatched;

    // Default 640x480 timing
    vga_timing_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PixEn      (pix_en),
        .Hpos       (hpos_d),
        .Vpos       (vpos_d),
        .Hsync      (hsync_d),
        .Vsync      (vsync_d),
        .Visible    (visible_d),
        .LineStart  (ls_d),
        .FrameStart (fs_d)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .FrameCnt   (fcnt_d)
`endif
    );

    // Small raster (32x17, active-high sync) so whole frames fit the run
    vga_timing_gen #(
        .H_VISIBLE (20), .H_FRONT (4), .H_SYNC (6), .H_BACK (2),
        .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (3), .V_BACK (2),
        .SYNC_POL  (1'b1)
    ) dut_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .PixEn      (pix_en),
        .Hpos       (hpos_s),
        .Vpos       (vpos_s),
        .Hsync      (hsync_s),
        .Vsync      (vsync_s),
        .Visible    (visible_s),
        .LineStart  (ls_s),
        .FrameStart (fs_s)
`ifdef VGA_FRAME_COUNTER_EN
        ,
        .FrameCnt   (fcnt_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set PixEn at a falling edge and return at the next falling edge
    task automatic tick(input logic pe);
        pix_en = pe;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pix_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        compared += 8;
        if (hpos_d !== 12'd0) begin mismatched++; $display("FAIL reset_hpos got %0d want 0", hpos_d); end
        if (vpos_d !== 12'd0) begin mismatched++; $display("FAIL reset_vpos got %0d want 0", vpos_d); end
        if (visible_d !== 1'b1) begin mismatched++; $display("FAIL reset_visible got %b want 1", visible_d); end
        if (hsync_d !== 1'b1 || vsync_d !== 1'b1) begin mismatched++; $display("FAIL reset_sync got %b%b want 11", hsync_d, vsync_d); end
        if (ls_d !== 1'b0 || fs_d !== 1'b0) begin mismatched++; $display("FAIL reset_pulses got %b%b want 00", ls_d, fs_d); end
        if (hsync_s !== 1'b0 || vsync_s !== 1'b0) begin mismatched++; $display("FAIL reset_sync_pol1 got %b%b want 00", hsync_s, vsync_s); end
        if (hpos_s !== 12'd0 || vpos_s !== 12'd0) begin mismatched++; $display("FAIL reset_small_pos got %0d,%0d want 0,0", hpos_s, vpos_s); end
        if (visible_s !== 1'b1) begin mismatched++; $display("FAIL reset_small_visible got %b want 1", visible_s); end
    endtask

    // One full 800-pixel line on the default raster
    task automatic test_line();
        int ls_count;
        int hs_count;
        int eh;
        int ev;
        logic exp_hs;
        logic exp_vis;
        do_reset();
        ls_count = 0;
        hs_count = 0;
        for (int i = 1; i <= 800; i++) begin
            tick(1'b1);
            eh = i % 800;
            ev = i / 800;
            exp_hs  = (eh >= 656 && eh <= 751) ? 1'b0 : 1'b1;
            exp_vis = (eh < 640);
            compared += 5;
            if (hpos_d !== 12'(eh) || vpos_d !== 12'(ev)) begin
                mismatched++; $display("FAIL line_pos i=%0d got %0d,%0d want %0d,%0d", i, hpos_d, vpos_d, eh, ev);
            end
            if (hsync_d !== exp_hs) begin mismatched++; $display("FAIL line_hsync h=%0d got %b want %b", eh, hsync_d, exp_hs); end
            if (visible_d !== exp_vis) begin mismatched++; $display("FAIL line_visible h=%0d got %b want %b", eh, visible_d, exp_vis); end
            if (ls_d !== (eh == 0)) begin mismatched++; $display("FAIL line_linestart h=%0d got %b want %b", eh, ls_d, (eh == 0)); end
            if (fs_d !== 1'b0) begin mismatched++; $display("FAIL line_framestart h=%0d got %b want 0", eh, fs_d); end
            if (ls_d) ls_count++;
            if (!hsync_d) hs_count++;
        end
        compared += 3;
        if (ls_count != 1) begin mismatched++; $display("FAIL line_ls_count got %0d want 1", ls_count); end
        if (hs_count != 96) begin mismatched++; $display("FAIL line_hsync_width got %0d want 96", hs_count); end
        if (vsync_d !== 1'b1) begin mismatched++; $display("FAIL line_vsync got %b want 1", vsync_d); end
    endtask

    // Three whole frames on the small raster, back-to-back PixEn
    task automatic test_frame();
        int eh;
        int ev;
        int fs_count;
        int vs_count;
        logic exp_hs, exp_vs, exp_vis;
        do_reset();
        eh = 0;
        ev = 0;
        fs_count = 0;
        vs_count = 0;
        for (int t = 1; t <= 3 * 544; t++) begin
            if (eh == 31) begin
                eh = 0;
                ev = (ev == 16) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
            tick(1'b1);
            exp_hs  = (eh >= 24 && eh <= 29);
            exp_vs  = (ev >= 12 && ev <= 14);
            exp_vis = (eh < 20) && (ev < 10);
            compared += 6;
            if (hpos_s !== 12'(eh) || vpos_s !== 12'(ev)) begin
                mismatched++; $display("FAIL frame_pos t=%0d got %0d,%0d want %0d,%0d", t, hpos_s, vpos_s, eh, ev);
            end
            if (hsync_s !== exp_hs) begin mismatched++; $display("FAIL frame_hsync t=%0d got %b want %b", t, hsync_s, exp_hs); end
            if (vsync_s !== exp_vs) begin mismatched++; $display("FAIL frame_vsync t=%0d got %b want %b", t, vsync_s, exp_vs); end
            if (visible_s !== exp_vis) begin mismatched++; $display("FAIL frame_visible t=%0d got %b want %b", t, visible_s, exp_vis); end
            if (ls_s !== (eh == 0)) begin mismatched++; $display("FAIL frame_linestart t=%0d got %b want %b", t, ls_s, (eh == 0)); end
            if (fs_s !== (eh == 0 && ev == 0)) begin mismatched++; $display("FAIL frame_framestart t=%0d got %b want %b", t, fs_s, (eh == 0 && ev == 0)); end
            if (fs_s) fs_count++;
            if (vsync_s) vs_count++;
            if (t % 544 == 0) begin
                compared += 2;
                if (fs_count != 1) begin mismatched++; $display("FAIL frame_fs_count t=%0d got %0d want 1", t, fs_count); end
                if (vs_count != 96) begin mismatched++; $display("FAIL frame_vsync_width t=%0d got %0d want 96", t, vs_count); end
`ifdef VGA_FRAME_COUNTER_EN
                compared++;
                if (fcnt_s !== 16'(t / 544)) begin mismatched++; $display("FAIL frame_cnt t=%0d got %0d want %0d", t, fcnt_s, t / 544); end
`endif
                fs_count = 0;
                vs_count = 0;
            end
        end
    endtask

    // PixEn pattern 1,0,0,1 repeated on the default raster across a line wrap
    task automatic test_pixen_gap();
        logic pat [4];
        int eh;
        int ls_count;
        logic pe;
        logic prev_hs, prev_vis;
        logic [11:0] prev_v;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        do_reset();
        eh = 0;
        ls_count = 0;
        for (int t = 0; t < 1700; t++) begin
            pe       = pat[t % 4];
            prev_hs  = hsync_d;
            prev_vis = visible_d;
            prev_v   = vpos_d;
            if (pe) eh = (eh == 799) ? 0 : eh + 1;
            tick(pe);
            compared += 2;
            if (hpos_d !== 12'(eh)) begin mismatched++; $display("FAIL gap_hpos t=%0d got %0d want %0d", t, hpos_d, eh); end
            if (ls_d !== (pe && eh == 0)) begin mismatched++; $display("FAIL gap_linestart t=%0d got %b want %b", t, ls_d, (pe && eh == 0)); end
            if (!pe) begin
                compared++;
                if (hsync_d !== prev_hs || visible_d !== prev_vis || vpos_d !== prev_v || fs_d !== 1'b0) begin
                    mismatched++; $display("FAIL gap_hold t=%0d outputs changed with PixEn=0", t);
                end
            end
            if (ls_d) ls_count++;
        end
        compared += 2;
        if (ls_count != 1) begin mismatched++; $display("FAIL gap_ls_count got %0d want 1", ls_count); end
        if (vpos_d !== 12'd1) begin mismatched++; $display("FAIL gap_vpos got %0d want 1", vpos_d); end
    endtask

    // Asynchronous reset in the middle of the horizontal sync pulse
    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 700; i++) tick(1'b1);
        compared++;
        if (hpos_d !== 12'd700 || hsync_d !== 1'b0 || visible_d !== 1'b0) begin
            mismatched++; $display("FAIL areset_pre got h=%0d hs=%b vis=%b want h=700 hs=0 vis=0", hpos_d, hsync_d, visible_d);
        end
        rst_n = 1'b0;
        #1;
        compared += 3;
        if (hpos_d !== 12'd0 || vpos_d !== 12'd0) begin mismatched++; $display("FAIL areset_pos got %0d,%0d want 0,0", hpos_d, vpos_d); end
        if (hsync_d !== 1'b1 || vsync_d !== 1'b1) begin mismatched++; $display("FAIL areset_sync got %b%b want 11", hsync_d, vsync_d); end
        if (visible_d !== 1'b1 || ls_d !== 1'b0) begin mismatched++; $display("FAIL areset_flags got vis=%b ls=%b want 1,0", visible_d, ls_d); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1);
        compared++;
        if (hpos_d !== 12'd1 || vpos_d !== 12'd0) begin mismatched++; $display("FAIL areset_restart got %0d,%0d want 1,0", hpos_d, vpos_d); end
    endtask

`ifdef VGA_FRAME_COUNTER_EN
    // Counter wrap 65535 -> 0 on the small raster
    task automatic test_frame_cnt_wrap();
        do_reset();
        force dut_s.FrameCnt = 16'hffff;
        @(negedge clk);
        release dut_s.FrameCnt;
        compared++;
        if (fcnt_s !== 16'hffff) begin mismatched++; $display("FAIL cnt_preload got %0d want 65535", fcnt_s); end
        for (int i = 0; i < 544; i++) tick(1'b1);
        compared++;
        if (fcnt_s !== 16'd0 || fs_s !== 1'b1) begin mismatched++; $display("FAIL cnt_wrap got cnt=%0d fs=%b want 0,1", fcnt_s, fs_s); end
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        pix_en     = 1'b0;
        test_reset();
        test_line();
        test_frame();
        test_pixen_gap();
        test_async_reset();
`ifdef VGA_FRAME_COUNTER_EN
        test_frame_cnt_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
